// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch stage with in-order prefetch queue
//
// Issues word-addressed requests on a req/gnt/rvalid instruction memory port,
// keeps up to MAX_OUT requests in flight, and buffers returned words in a
// DEPTH-entry queue that feeds the IF/ID register through out_valid/out_ready.
// A redirect empties the queue and marks every still-pending response as
// stale. Those stale responses are discarded when they return.
//
// Ports:
//   clk, clr                         clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt      request channel (issue on req & gnt)
//   imem_rvalid/imem_rdata           in-order response channel
//   redirect_valid/redirect_pc       flush and restart fetch at redirect_pc
//   out_valid/out_ready              queue head handshake
//   out_instr/out_pc                 queue head instruction and its address
//   perf_fetched/perf_dropped        delivered / discarded counters
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds the perf counter ports).
module fetch_queue_unit #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter int MAX_OUT = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            clr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped,
`endif
    output logic [XLEN-1:0] out_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(MAX_OUT + 1);

    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [IW-1:0]   inflight;
    logic [IW-1:0]   drop;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic            rst_hold;

    logic            issue;
    logic            resp;
    logic            discard;
    logic            push;
    logic            pop;
    logic [IW-1:0]   inflight_next;

    // Queue space is reserved for every live request at issue time, so a
    // returning response can always be pushed.
    always_comb begin
        imem_req = !clr && !rst_hold && !redirect_valid
                   && (int'(inflight) < MAX_OUT)
                   && ((int'(count) + int'(inflight) - int'(drop)) < DEPTH);
    end

    assign imem_addr = fetch_pc;
    assign out_valid = !clr && (count != '0);
    assign out_instr = out_valid ? q_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? q_pc[rd_ptr] : '0;

    assign issue   = imem_req && imem_gnt;
    // A response with nothing outstanding is treated as noise.
    assign resp    = imem_rvalid && (inflight != '0);
    // The word returning in a redirect cycle belongs to the old stream.
    assign discard = resp && (redirect_valid || (drop != '0));
    assign push    = resp && !discard;
    assign pop     = out_valid && out_ready && !redirect_valid;

    assign inflight_next = inflight + IW'(issue) - IW'(resp);

    always_ff @(posedge clk) begin
        if (clr) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
            inflight <= inflight_next;
            if (redirect_valid) begin
                // Everything still outstanding after this cycle is stale;
                // this also covers any drop left over from an earlier redirect.
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop     <= inflight_next;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 1'b1;
                end
                if (discard) begin
                    drop <= drop - 1'b1;
                end
                if (push) begin
                    q_pc[wr_ptr]    <= resp_pc;
                    q_instr[wr_ptr] <= imem_rdata;
                    wr_ptr          <= wr_ptr + 1'b1;
                    resp_pc         <= resp_pc + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (discard) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
        end
    end
`endif

    rvalid_needs_inflight: assert property (@(posedge clk) disable iff (clr)
        imem_rvalid |-> (inflight != '0));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;

    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam int MAX_OUT = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic            clk = 1'b0;
    logic            clr;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_dropped;
`endif

    fetch_queue_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .clr(clr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched), .perf_dropped(perf_dropped),
`endif
        .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } pend_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    pend_t       pend[$];
    logic [31:0] mq[$];
    logic [31:0] popped_q[$];
    logic [31:0] exp_fetch;
    int          epoch;
    int          n_pop;
    int          n_drop;
    int          n_issue;
    logic        obs_req;
    logic [31:0] obs_pc;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        #1;
        chk("clr_req", {31'd0, imem_req}, 32'd0);
        chk("clr_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_pc", out_pc, 32'd0);
        chk("clr_instr", out_instr, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("post_req", {31'd0, imem_req}, 32'd0);
        chk("post_valid", {31'd0, out_valid}, 32'd0);
        chk("post_addr", imem_addr, RESET_PC);
        chk("post_pc", out_pc, 32'd0);
        pend.delete(); mq.delete(); popped_q.delete();
        exp_fetch = RESET_PC; epoch = 0;
        n_pop = 0; n_drop = 0; n_issue = 0;
    endtask

    // One clock cycle of stimulus plus a transaction-level model of the
    // stage: pending requests tagged by redirect epoch, delivered words held
    // in a plain queue, fetch addresses counted from the last restart point.
    task automatic step(input int gnt_pct, input int rdy_pct, input int rv_pct,
                        input bit redir, input logic [31:0] rpc);
        int          live;
        bit          exp_req;
        bit          popped;
        pend_t       e;
        @(negedge clk);
        imem_gnt = ($urandom % 100) < gnt_pct;
        out_ready = ($urandom % 100) < rdy_pct;
        redirect_valid = redir;
        redirect_pc = rpc;
        imem_rvalid = (pend.size() != 0) && (($urandom % 100) < rv_pct);
        imem_rdata = imem_rvalid ? mem_word(pend[0].addr) : $urandom;
        #1;
        live = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) live++;
        exp_req = !redir && (pend.size() < MAX_OUT) && (mq.size() + live < DEPTH);
        chk("req", {31'd0, imem_req}, {31'd0, exp_req});
        if (imem_req) chk("addr", imem_addr, exp_fetch);
        chk("valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("head_pc", out_pc, mq[0]);
            chk("head_instr", out_instr, mem_word(mq[0]));
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, n_pop);
        chk("perf_dropped", perf_dropped, n_drop);
`endif
        obs_req = imem_req;
        obs_pc = out_pc;
        popped = (mq.size() != 0) && out_ready && !redir;
        if (popped) begin
            popped_q.push_back(mq.pop_front());
            n_pop++;
        end
        if (imem_rvalid) begin
            e = pend.pop_front();
            if (redir || e.epoch != epoch) n_drop++;
            else mq.push_back(e.addr);
        end
        if (redir) begin
            mq.delete();
            epoch++;
            exp_fetch = rpc;
        end else if (exp_req && imem_gnt) begin
            pend.push_back('{addr: exp_fetch, epoch: epoch});
            exp_fetch = exp_fetch + 1;
            n_issue++;
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{rpc: 32'h0000_0040, e0: 32'h0000_0040, e1: 32'h0000_0041};
        vecs[1] = '{rpc: 32'hFFFF_FFFF, e0: 32'hFFFF_FFFF, e1: 32'h0000_0000};
        vecs[2] = '{rpc: 32'h7FFF_FFFF, e0: 32'h7FFF_FFFF, e1: 32'h8000_0000};
        vecs[3] = '{rpc: 32'h0000_0000, e0: 32'h0000_0000, e1: 32'h0000_0001};
        vecs[4] = '{rpc: 32'h1234_5678, e0: 32'h1234_5678, e1: 32'h1234_5679};

        // Full-rate streaming: one instruction per cycle from RESET_PC.
        do_reset();
        for (int i = 0; i < 10; i++) step(100, 100, 100, 0, 0);
        chk("t1_pops", n_pop, 8);
        for (int i = 0; i < 4; i++) chk("t1_seq", popped_q[i], i);

        // Stalled consumer fills the queue, then drains once released.
        do_reset();
        for (int i = 0; i < 12; i++) step(100, 0, 100, 0, 0);
        chk("t2_issues", n_issue, DEPTH);
        chk("t2_req_low", {31'd0, obs_req}, 32'd0);
        chk("t2_head_held", obs_pc, 32'd0);
        for (int i = 0; i < 8; i++) step(100, 100, 100, 0, 0);
        chk("t2_resume", popped_q[0], 32'd0);
        chk("t2_resume_n", {31'd0, n_pop >= 6}, 32'd1);

        // Redirect with two requests outstanding and no response that cycle.
        do_reset();
        step(100, 100, 0, 0, 0);
        step(100, 100, 0, 0, 0);
        step(100, 100, 0, 1, 32'h40);
        for (int i = 0; i < 8; i++) step(100, 100, 100, 0, 0);
        chk("t3_dropped", n_drop, 2);
        chk("t3_first_pc", popped_q[0], 32'h40);

        // Redirect in the same cycle a response returns.
        do_reset();
        step(100, 100, 0, 0, 0);
        step(100, 100, 0, 0, 0);
        step(100, 100, 100, 1, 32'h80);
        chk("t4_req_redirect", {31'd0, obs_req}, 32'd0);
        for (int i = 0; i < 8; i++) step(100, 100, 100, 0, 0);
        chk("t4_dropped", n_drop, 2);
        chk("t4_first_pc", popped_q[0], 32'h80);

        // Redirect target table, including address wrap.
        foreach (vecs[v]) begin
            do_reset();
            step(100, 100, 100, 0, 0);
            step(100, 100, 100, 1, vecs[v].rpc);
            popped_q.delete();
            for (int i = 0; i < 6; i++) step(100, 100, 100, 0, 0);
            chk("vec_pc0", popped_q[0], vecs[v].e0);
            chk("vec_pc1", popped_q[1], vecs[v].e1);
        end

        // Reset in mid-operation with a partly filled queue and requests out.
        do_reset();
        for (int i = 0; i < 4; i++) step(100, 0, 100, 0, 0);
        step(100, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 6; i++) step(100, 100, 100, 0, 0);
        chk("t6_restart", popped_q[0], RESET_PC);

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(20, 100), $urandom_range(0, 100), $urandom_range(10, 100),
                 ($urandom % 25) == 0, ($urandom % 4 == 0) ? 32'hFFFF_FFFE : $urandom);
        end
        chk("rand_progress", {31'd0, n_pop > 100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
